wb_master_port: RTL and testbench



---
 rtl/wb_master_pkg.sv | 47 ++++
 rtl/wb_lane_steer.sv | 48 ++++
 rtl/wb_master_port.sv | 194 +++++++++++++++++++
 tb/tb_wb_master_port.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_master_pkg.sv
// wb_master_pkg: shared encodings, FSM state and lane helpers for the Wishbone master port.
package wb_master_pkg;

  localparam logic [1:0] SIZE_BYTE  = 2'd0;
  localparam logic [1:0] SIZE_HALF  = 2'd1;
  localparam logic [1:0] SIZE_WORD  = 2'd2;
  localparam logic [1:0] SIZE_DWORD = 2'd3;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_BUS      = 2'd1,
    ERR_MISALIGN = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } wb_err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } wb_state_e;

  // Byte-select mask for an access of 2^size bytes at a byte offset within the bus word.
  function automatic logic [7:0] sel_mask(input logic [1:0] size, input logic [2:0] offset);
    logic [7:0] base;
    case (size)
      SIZE_BYTE: base = 8'h01;
      SIZE_HALF: base = 8'h03;
      SIZE_WORD: base = 8'h0F;
      default:   base = 8'hFF;
    endcase
    return base << offset;
  endfunction

  // Natural alignment check; a dword can never be issued on a 32-bit bus.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] offset,
                                      input logic bus64);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = offset[0];
      SIZE_WORD: mis = |offset[1:0];
      default:   mis = !bus64 || (|offset);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/wb_lane_steer.sv
// wb_lane_steer: combinational byte-lane steering; shifts store data onto its lanes and
// extracts/extends load data. Shared with the instruction-fetch port.
module wb_lane_steer
  import wb_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [$clog2(DATA_WIDTH/8)-1:0] st_offset_i,
  input  logic [DATA_WIDTH-1:0]           st_data_i,
  output logic [DATA_WIDTH-1:0]           st_data_o,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] ld_offset_i,
  input  logic [1:0]                      ld_size_i,
  input  logic                            ld_signed_i,
  input  logic [DATA_WIDTH-1:0]           ld_data_i,
  output logic [DATA_WIDTH-1:0]           ld_data_o
);

  logic [DATA_WIDTH-1:0] shifted_c;
  logic [DATA_WIDTH-1:0] mask_c;
  logic                  sign_c;

  assign st_data_o = st_data_i << {st_offset_i, 3'b000};
  assign shifted_c = ld_data_i >> {ld_offset_i, 3'b000};

  // Field mask and sign bit of the loaded quantity after it is moved to lane 0.
  always_comb begin
    mask_c = '1;
    sign_c = shifted_c[DATA_WIDTH-1];
    case (ld_size_i)
      SIZE_BYTE: begin
        mask_c = DATA_WIDTH'(8'hFF);
        sign_c = shifted_c[7];
      end
      SIZE_HALF: begin
        mask_c = DATA_WIDTH'(16'hFFFF);
        sign_c = shifted_c[15];
      end
      SIZE_WORD: begin
        mask_c = DATA_WIDTH'(32'hFFFF_FFFF);
        sign_c = shifted_c[31];
      end
      default: ;
    endcase
  end

  assign ld_data_o = (shifted_c & mask_c) | ((ld_signed_i && sign_c) ? ~mask_c : '0);

endmodule

// File: rtl/wb_master_port.sv
// wb_master_port: Wishbone classic master issuing one registered bus cycle per load/store.
// Define WB_MASTER_TIMEOUT_EN to abort cycles left unanswered for TIMEOUT_CYCLES.
module wb_master_port
  import wb_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [ADDR_WIDTH-1:0]   transaction_addr_i,
  input  logic [DATA_WIDTH-1:0]   transaction_data_i,
  input  logic [1:0]              transaction_size_i,
  input  logic                    transaction_signed_i,
  input  logic                    transaction_we_i,
  input  logic                    transaction_start_i,
  input  logic                    transaction_clear_ready_i,
  output logic                    transaction_ready_o,
  output logic [1:0]              transaction_error_o,
  output logic [DATA_WIDTH-1:0]   transaction_data_o,
  output logic [ADDR_WIDTH-1:0]   wb_addr_o,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic                    wb_we_o,
  output logic                    wb_stb_o,
  output logic                    wb_cyc_o,
  input  logic [DATA_WIDTH-1:0]   wb_data_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned OFF_W     = $clog2(SEL_WIDTH);

  wb_state_e             state_q, state_d;
  wb_err_e               err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                  we_q, we_d, stb_q, stb_d, ready_q, ready_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic [1:0]            size_q, size_d;
  logic                  sgn_q, sgn_d;
  logic [OFF_W-1:0]      req_off_c;
  logic                  req_mis_c;
  logic                  bus_end_c;
  logic [DATA_WIDTH-1:0] st_data_c, ld_data_c;

  assign req_off_c = transaction_addr_i[OFF_W-1:0];
  assign req_mis_c = misaligned(transaction_size_i, 3'(req_off_c), DATA_WIDTH == 64);

  wb_lane_steer #(.DATA_WIDTH(DATA_WIDTH)) u_lane_steer (
    .st_offset_i (req_off_c),
    .st_data_i   (transaction_data_i),
    .st_data_o   (st_data_c),
    .ld_offset_i (off_q),
    .ld_size_i   (size_q),
    .ld_signed_i (sgn_q),
    .ld_data_i   (wb_data_i),
    .ld_data_o   (ld_data_c)
  );

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_c;
  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus_end_c = wb_err_i || wb_ack_i || timeout_c;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign bus_end_c = wb_err_i || wb_ack_i;
`endif

  // Next-state and next-register values.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    sel_d   = sel_q;
    we_d    = we_q;
    stb_d   = stb_q;
    ready_d = ready_q;
    off_d   = off_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
`ifdef WB_MASTER_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_BUSY: begin
        if (bus_end_c) begin
          state_d = ST_DONE;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          ready_d = 1'b1;
          rdata_d = '0;
          if (wb_err_i) begin
            err_d = ERR_BUS;
          end else if (wb_ack_i) begin
            err_d = ERR_OK;
            if (!we_q) rdata_d = ld_data_c;
          end
`ifdef WB_MASTER_TIMEOUT_EN
          else begin
            err_d = ERR_TIMEOUT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: begin
        // IDLE and DONE both accept; start takes priority over clear.
        if (transaction_start_i) begin
          ready_d = 1'b0;
          if (req_mis_c) begin
            state_d = ST_DONE;
            ready_d = 1'b1;
            err_d   = ERR_MISALIGN;
            rdata_d = '0;
          end else begin
            state_d = ST_BUSY;
            addr_d  = {transaction_addr_i[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
            wdata_d = st_data_c;
            sel_d   = SEL_WIDTH'(sel_mask(transaction_size_i, 3'(req_off_c)));
            we_d    = transaction_we_i;
            stb_d   = 1'b1;
            off_d   = req_off_c;
            size_d  = transaction_size_i;
            sgn_d   = transaction_signed_i;
`ifdef WB_MASTER_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end else if (state_q == ST_DONE && transaction_clear_ready_i) begin
          state_d = ST_IDLE;
          ready_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      err_q   <= ERR_OK;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      stb_q   <= 1'b0;
      ready_q <= 1'b0;
      off_q   <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      stb_q   <= stb_d;
      ready_q <= ready_d;
      off_q   <= off_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
`ifdef WB_MASTER_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign transaction_ready_o = ready_q;
  assign transaction_error_o = err_q;
  assign transaction_data_o  = rdata_q;
  assign wb_addr_o           = addr_q;
  assign wb_data_o           = wdata_q;
  assign wb_sel_o            = sel_q;
  assign wb_we_o             = we_q;
  assign wb_stb_o            = stb_q;
  assign wb_cyc_o            = stb_q;

endmodule

// File: tb/tb_wb_master_port.sv
// tb_wb_master_port: scoreboard bench for a 32-bit and a 64-bit wb_master_port instance.
`timescale 1ns/1ps
module tb_wb_master_port;

  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]  err;
    logic [63:0] data;
  } exp_t;
  exp_t sb_a[$];
  exp_t sb_b[$];

  // 32-bit instance
  logic [31:0] a_addr, a_wdata, a_rdata, a_wbaddr, a_wbdata, a_wbdin;
  logic [1:0]  a_size, a_err;
  logic        a_sgn, a_we, a_start, a_clr, a_ready, a_wbwe, a_stb, a_cyc, a_ack, a_wberr;
  logic [3:0]  a_sel;

  // 64-bit instance
  logic [31:0] b_addr, b_wbaddr;
  logic [63:0] b_wdata, b_rdata, b_wbdata, b_wbdin;
  logic [1:0]  b_size, b_err;
  logic        b_sgn, b_we, b_start, b_clr, b_ready, b_wbwe, b_stb, b_cyc, b_ack, b_wberr;
  logic [7:0]  b_sel;

  wb_master_port #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) u_dut32 (
    .clk_i(clk), .rst_n_i(rst_n),
    .transaction_addr_i(a_addr), .transaction_data_i(a_wdata), .transaction_size_i(a_size),
    .transaction_signed_i(a_sgn), .transaction_we_i(a_we), .transaction_start_i(a_start),
    .transaction_clear_ready_i(a_clr), .transaction_ready_o(a_ready),
    .transaction_error_o(a_err), .transaction_data_o(a_rdata),
    .wb_addr_o(a_wbaddr), .wb_data_o(a_wbdata), .wb_sel_o(a_sel), .wb_we_o(a_wbwe),
    .wb_stb_o(a_stb), .wb_cyc_o(a_cyc), .wb_data_i(a_wbdin), .wb_ack_i(a_ack), .wb_err_i(a_wberr)
  );

  wb_master_port #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) u_dut64 (
    .clk_i(clk), .rst_n_i(rst_n),
    .transaction_addr_i(b_addr), .transaction_data_i(b_wdata), .transaction_size_i(b_size),
    .transaction_signed_i(b_sgn), .transaction_we_i(b_we), .transaction_start_i(b_start),
    .transaction_clear_ready_i(b_clr), .transaction_ready_o(b_ready),
    .transaction_error_o(b_err), .transaction_data_o(b_rdata),
    .wb_addr_o(b_wbaddr), .wb_data_o(b_wbdata), .wb_sel_o(b_sel), .wb_we_o(b_wbwe),
    .wb_stb_o(b_stb), .wb_cyc_o(b_cyc), .wb_data_i(b_wbdin), .wb_ack_i(b_ack), .wb_err_i(b_wberr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumers: every rising ready must match the oldest expected result.
  logic a_prev = 1'b0;
  always @(posedge clk) begin : mon_a
    exp_t e;
    #1;
    if (a_ready === 1'b1 && a_prev !== 1'b1) begin
      n_tests++;
      if (sb_a.size() == 0) begin
        n_fail++;
        $display("FAIL a_result_unexpected: got err=%0d data=%h, none expected", a_err, a_rdata);
      end else begin
        e = sb_a.pop_front();
        if (a_err !== e.err || a_rdata !== e.data[31:0]) begin
          n_fail++;
          $display("FAIL a_result: got err=%0d data=%h want err=%0d data=%h",
                   a_err, a_rdata, e.err, e.data[31:0]);
        end
      end
    end
    a_prev = a_ready;
  end

  logic b_prev = 1'b0;
  always @(posedge clk) begin : mon_b
    exp_t e;
    #1;
    if (b_ready === 1'b1 && b_prev !== 1'b1) begin
      n_tests++;
      if (sb_b.size() == 0) begin
        n_fail++;
        $display("FAIL b_result_unexpected: got err=%0d data=%h, none expected", b_err, b_rdata);
      end else begin
        e = sb_b.pop_front();
        if (b_err !== e.err || b_rdata !== e.data) begin
          n_fail++;
          $display("FAIL b_result: got err=%0d data=%h want err=%0d data=%h",
                   b_err, b_rdata, e.err, e.data);
        end
      end
    end
    b_prev = b_ready;
  end

  task automatic a_issue(input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] size,
                         input logic sgn, input logic we, input logic [1:0] e_err,
                         input logic [31:0] e_data, input logic push);
    exp_t e;
    a_addr = addr; a_wdata = wdata; a_size = size; a_sgn = sgn; a_we = we; a_start = 1'b1;
    if (push) begin
      e.err = e_err; e.data = {32'h0, e_data};
      sb_a.push_back(e);
    end
    tick();
    a_start = 1'b0;
  endtask

  task automatic b_issue(input logic [31:0] addr, input logic [63:0] wdata, input logic [1:0] size,
                         input logic sgn, input logic we, input logic [1:0] e_err,
                         input logic [63:0] e_data);
    exp_t e;
    b_addr = addr; b_wdata = wdata; b_size = size; b_sgn = sgn; b_we = we; b_start = 1'b1;
    e.err = e_err; e.data = e_data;
    sb_b.push_back(e);
    tick();
    b_start = 1'b0;
  endtask

  task automatic a_clear();
    a_clr = 1'b1; tick(); a_clr = 1'b0;
  endtask

  task automatic b_clear();
    b_clr = 1'b1; tick(); b_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {a_addr, a_wdata, a_size, a_sgn, a_we, a_start, a_clr, a_wbdin, a_ack, a_wberr} = '0;
    {b_addr, b_wdata, b_size, b_sgn, b_we, b_start, b_clr, b_wbdin, b_ack, b_wberr} = '0;
    tick(); tick();
    n_tests++;
    if ({a_ready, a_err, a_rdata, a_wbaddr, a_wbdata, a_sel, a_wbwe, a_stb, a_cyc} !== '0) begin
      n_fail++;
      $display("FAIL reset_a: got %h want 0",
               {a_ready, a_err, a_rdata, a_wbaddr, a_wbdata, a_sel, a_wbwe, a_stb, a_cyc});
    end
    n_tests++;
    if ({b_ready, b_err, b_rdata, b_wbaddr, b_wbdata, b_sel, b_wbwe, b_stb, b_cyc} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: got %h want 0",
               {b_ready, b_err, b_rdata, b_wbaddr, b_wbdata, b_sel, b_wbwe, b_stb, b_cyc});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_store_byte();
    a_wbdin = 32'hFFFF_FFFF;
    a_issue(32'h1003, 32'h0000_00AB, 2'd0, 1'b0, 1'b1, 2'd0, 32'h0, 1'b1);
    n_tests++;
    if ({a_stb, a_cyc, a_wbwe, a_sel, a_ready} !== {1'b1, 1'b1, 1'b1, 4'b1000, 1'b0}) begin
      n_fail++;
      $display("FAIL st_byte_ctrl: got %b want %b", {a_stb, a_cyc, a_wbwe, a_sel, a_ready}, 8'b1111_0000);
    end
    n_tests++;
    if (a_wbaddr !== 32'h1000 || a_wbdata !== 32'hAB00_0000) begin
      n_fail++;
      $display("FAIL st_byte_bus: got addr=%h data=%h want addr=00001000 data=ab000000", a_wbaddr, a_wbdata);
    end
    a_ack = 1'b1; tick(); a_ack = 1'b0;
    n_tests++;
    if ({a_ready, a_stb, a_cyc, a_wbwe, a_sel} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'b0000}) begin
      n_fail++;
      $display("FAIL st_byte_done: got %b want 10000000", {a_ready, a_stb, a_cyc, a_wbwe, a_sel});
    end
    a_clear();
    n_tests++;
    if (a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_ready: got %b want 0", a_ready);
    end
  endtask

  task automatic test_load_half();
    for (int s = 1; s >= 0; s--) begin
      a_issue(32'h2002, 32'h0, 2'd1, 1'(s), 1'b0, 2'd0, (s == 1) ? 32'hFFFF_8001 : 32'h0000_8001, 1'b1);
      n_tests++;
      if (a_sel !== 4'b1100 || a_wbaddr !== 32'h2000 || a_wbwe !== 1'b0) begin
        n_fail++;
        $display("FAIL ld_half_bus: got sel=%b addr=%h we=%b want sel=1100 addr=00002000 we=0",
                 a_sel, a_wbaddr, a_wbwe);
      end
      a_wbdin = 32'h8001_1234; a_ack = 1'b1; tick(); a_ack = 1'b0;
      n_tests++;
      if (a_ready !== 1'b1 || a_stb !== 1'b0) begin
        n_fail++;
        $display("FAIL ld_half_latency: got ready=%b stb=%b want ready=1 stb=0", a_ready, a_stb);
      end
      a_clear();
    end
  endtask

  task automatic test_wait_state();
    a_issue(32'h3000, 32'h0, 2'd2, 1'b1, 1'b0, 2'd0, 32'hDEAD_BEEF, 1'b1);
    a_addr = 32'h7000; a_start = 1'b1; tick(); a_start = 1'b0;
    n_tests++;
    if (a_wbaddr !== 32'h3000 || a_stb !== 1'b1 || a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignores_start: got addr=%h stb=%b ready=%b want addr=00003000 stb=1 ready=0",
               a_wbaddr, a_stb, a_ready);
    end
    tick(); tick();
    n_tests++;
    if (a_stb !== 1'b1 || a_sel !== 4'b1111) begin
      n_fail++;
      $display("FAIL wait_hold: got stb=%b sel=%b want stb=1 sel=1111", a_stb, a_sel);
    end
    a_wbdin = 32'hDEAD_BEEF; a_ack = 1'b1; tick(); a_ack = 1'b0;
    a_clear();
    n_tests++;
    if (a_ready !== 1'b0 || a_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_after_clear: got ready=%b stb=%b want 0 0", a_ready, a_stb);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] maddr [4] = '{32'h3002, 32'h3000, 32'h3001, 32'h3006};
    logic [1:0]  msize [4] = '{2'd2, 2'd3, 2'd1, 2'd2};
    logic        mwe   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      a_issue(maddr[i], 32'h1234_5678, msize[i], 1'b1, mwe[i], 2'd2, 32'h0, 1'b1);
      n_tests++;
      if (a_ready !== 1'b1 || a_err !== 2'd2 || a_stb !== 1'b0 || a_cyc !== 1'b0) begin
        n_fail++;
        $display("FAIL misaligned_%0d: got ready=%b err=%0d stb=%b want ready=1 err=2 stb=0",
                 i, a_ready, a_err, a_stb);
      end
      a_clear();
    end
  endtask

  task automatic test_err_back_to_back();
    a_issue(32'h5000, 32'h0, 2'd2, 1'b0, 1'b0, 2'd1, 32'h0, 1'b1);
    a_wbdin = 32'h1234_5678; a_ack = 1'b1; a_wberr = 1'b1; tick(); a_ack = 1'b0; a_wberr = 1'b0;
    n_tests++;
    if (a_ready !== 1'b1 || a_err !== 2'd1 || a_rdata !== 32'h0 || a_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL err_wins: got ready=%b err=%0d data=%h stb=%b want 1 1 0 0",
               a_ready, a_err, a_rdata, a_stb);
    end
    a_clr = 1'b1;
    a_issue(32'h5004, 32'h0, 2'd0, 1'b1, 1'b0, 2'd0, 32'h0000_0077, 1'b1);
    a_clr = 1'b0;
    n_tests++;
    if (a_ready !== 1'b0 || a_stb !== 1'b1 || a_wbaddr !== 32'h5004 || a_sel !== 4'b0001) begin
      n_fail++;
      $display("FAIL start_beats_clear: got ready=%b stb=%b addr=%h sel=%b want 0 1 00005004 0001",
               a_ready, a_stb, a_wbaddr, a_sel);
    end
    a_wbdin = 32'h0000_0077; a_ack = 1'b1; tick(); a_ack = 1'b0;
    a_clear();
  endtask

  task automatic test_dw64();
    b_wbdin = 64'hFFFF_FFFF_FFFF_FFFF;
    b_issue(32'h4008, 64'h1122_3344_5566_7788, 2'd3, 1'b0, 1'b1, 2'd0, 64'h0);
    n_tests++;
    if (b_sel !== 8'hFF || b_wbaddr !== 32'h4008 || b_wbdata !== 64'h1122_3344_5566_7788 || b_stb !== 1'b1) begin
      n_fail++;
      $display("FAIL dw_store: got sel=%h addr=%h data=%h stb=%b", b_sel, b_wbaddr, b_wbdata, b_stb);
    end
    b_ack = 1'b1; tick(); b_ack = 1'b0;
    b_clear();
    b_issue(32'h4005, 64'h0, 2'd0, 1'b1, 1'b0, 2'd0, 64'hFFFF_FFFF_FFFF_FF9C);
    n_tests++;
    if (b_sel !== 8'h20 || b_wbaddr !== 32'h4000) begin
      n_fail++;
      $display("FAIL b_byte_bus: got sel=%h addr=%h want sel=20 addr=00004000", b_sel, b_wbaddr);
    end
    b_wbdin = 64'h0000_9C00_0000_0000; b_ack = 1'b1; tick(); b_ack = 1'b0;
    b_clear();
    b_issue(32'h4006, 64'h0000_0000_0000_BEEF, 2'd1, 1'b0, 1'b1, 2'd0, 64'h0);
    n_tests++;
    if (b_sel !== 8'hC0 || b_wbdata !== 64'hBEEF_0000_0000_0000) begin
      n_fail++;
      $display("FAIL b_half_store: got sel=%h data=%h want sel=c0 data=beef000000000000", b_sel, b_wbdata);
    end
    b_ack = 1'b1; tick(); b_ack = 1'b0;
    b_clear();
    b_issue(32'h4004, 64'h0, 2'd2, 1'b0, 1'b0, 2'd0, 64'h0000_0000_89AB_CDEF);
    b_wbdin = 64'h89AB_CDEF_0000_0000; b_ack = 1'b1; tick(); b_ack = 1'b0;
    b_clear();
  endtask

  task automatic test_timeout();
`ifdef WB_MASTER_TIMEOUT_EN
    a_issue(32'h6000, 32'h0, 2'd2, 1'b0, 1'b0, 2'd3, 32'h0, 1'b1);
    for (int i = 0; i < TO; i++) begin
      n_tests++;
      if (a_stb !== 1'b1 || a_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_busy_%0d: got stb=%b ready=%b want stb=1 ready=0", i, a_stb, a_ready);
      end
      tick();
    end
    n_tests++;
    if (a_ready !== 1'b1 || a_err !== 2'd3 || a_stb !== 1'b0 || a_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL timeout_abort: got ready=%b err=%0d stb=%b data=%h want 1 3 0 0",
               a_ready, a_err, a_stb, a_rdata);
    end
    a_wbdin = 32'hFFFF_FFFF; a_ack = 1'b1; tick(); a_ack = 1'b0;
    n_tests++;
    if (a_ready !== 1'b1 || a_err !== 2'd3 || a_rdata !== 32'h0 || a_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL late_ack: got ready=%b err=%0d data=%h stb=%b want 1 3 0 0",
               a_ready, a_err, a_rdata, a_stb);
    end
    a_clear();
`else
    a_issue(32'h6000, 32'h0, 2'd2, 1'b0, 1'b0, 2'd0, 32'hCAFE_F00D, 1'b1);
    for (int i = 0; i < 20; i++) tick();
    n_tests++;
    if (a_stb !== 1'b1 || a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL no_timeout_wait: got stb=%b ready=%b want stb=1 ready=0", a_stb, a_ready);
    end
    a_wbdin = 32'hCAFE_F00D; a_ack = 1'b1; tick(); a_ack = 1'b0;
    n_tests++;
    if (a_ready !== 1'b1 || a_err !== 2'd0) begin
      n_fail++;
      $display("FAIL no_timeout_done: got ready=%b err=%0d want ready=1 err=0", a_ready, a_err);
    end
    a_clear();
`endif
  endtask

  task automatic test_reset_mid_busy();
    a_issue(32'h1004, 32'h0000_0055, 2'd2, 1'b0, 1'b1, 2'd0, 32'h0, 1'b0);
    n_tests++;
    if (a_stb !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_busy_pre: got stb=%b want 1", a_stb);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({a_ready, a_err, a_rdata, a_wbaddr, a_wbdata, a_sel, a_wbwe, a_stb, a_cyc} !== '0) begin
      n_fail++;
      $display("FAIL rst_async: got %h want 0",
               {a_ready, a_err, a_rdata, a_wbaddr, a_wbdata, a_sel, a_wbwe, a_stb, a_cyc});
    end
    tick();
    rst_n = 1'b1;
    a_ack = 1'b1; tick(); a_ack = 1'b0; tick();
    n_tests++;
    if (a_ready !== 1'b0 || a_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_result: got ready=%b stb=%b want 0 0", a_ready, a_stb);
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_half();
    test_wait_state();
    test_misaligned();
    test_err_back_to_back();
    test_dw64();
    test_timeout();
    test_reset_mid_busy();
    tick();
    n_tests++;
    if (sb_a.size() != 0 || sb_b.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending want 0/0", sb_a.size(), sb_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
